// File: rtl/key_pkg.sv
// Shared key codes and controller state encoding for the keypad entry path.
package key_pkg;

  localparam logic [4:0] KEY_DIG_MIN = 5'd1;
  localparam logic [4:0] KEY_DIG_MAX = 5'd10;
  localparam logic [4:0] KEY_BS      = 5'd11;
  localparam logic [4:0] KEY_CLR     = 5'd12;
  localparam logic [4:0] KEY_ENT     = 5'd13;

  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return (code >= KEY_DIG_MIN) && (code <= KEY_DIG_MAX);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Display-hold counter: load clears, enable counts up, stops at terminal count.
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = $clog2(HOLD_CYCLES);
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)                      cnt_q <= '0;
    else if (i_load)                cnt_q <= '0;
    else if (i_en && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
  end

  assign o_tc = (cnt_q == LAST);

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: BCD edit buffer, digit count, commit and timed display hold.
module key_entry_ctrl
  import key_pkg::*;
#(
  parameter int         DIGITS      = 8,
  parameter int         HOLD_CYCLES = 50_000_000,
  parameter logic [4:0] KEY_BS      = key_pkg::KEY_BS,
  parameter logic [4:0] KEY_CLR     = key_pkg::KEY_CLR,
  parameter logic [4:0] KEY_ENT     = key_pkg::KEY_ENT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_key_valid,
  input  logic [4:0]            i_key_value,
  output logic [4*DIGITS-1:0]   o_bcd8d,
  output logic [DIGITS-1:0]     o_blank,
  output logic [3:0]            o_digit_cnt,
  output logic                  o_commit_valid,
  output logic [4*DIGITS-1:0]   o_commit_bcd,
  output logic                  o_err,
  output logic                  o_hold
);

  localparam logic [3:0] DIG_N = 4'(DIGITS);

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   edit_q, edit_d;
  logic [4*DIGITS-1:0]   commit_q, commit_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DIGITS-1:0]     blank_d;
  logic                  err_d, clear, tmr_load, tmr_en, tmr_tc;
  logic [3:0]            dig;

  assign dig = 4'(i_key_value - 5'd1);

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (tmr_load),
    .i_en   (tmr_en),
    .o_tc   (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    edit_d   = edit_q;
    cnt_d    = cnt_q;
    commit_d = commit_q;
    err_d    = 1'b0;
    clear    = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    blank_d  = '0;
    case (state_q)
      ST_EDIT: if (i_key_valid) begin
        if (is_digit(i_key_value)) begin
          if (cnt_q < DIG_N) begin
            edit_d = {edit_q[4*DIGITS-5:0], dig};
            cnt_d  = cnt_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end else if (i_key_value == KEY_BS) begin
          if (cnt_q != 4'd0) begin
            edit_d = {4'h0, edit_q[4*DIGITS-1:4]};
            cnt_d  = cnt_q - 4'd1;
          end
        end else if (i_key_value == KEY_CLR) begin
          clear = 1'b1;
        end else if (i_key_value == KEY_ENT) begin
          if (cnt_q != 4'd0) begin
            commit_d = edit_q;
            state_d  = ST_COMMIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        tmr_load = 1'b1;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        tmr_en = 1'b1;
        // keys on the timeout cycle still follow hold rules, so err can coincide with exit
        if (i_key_valid) begin
          if (i_key_value == KEY_CLR) clear = 1'b1;
          else if (is_digit(i_key_value) || i_key_value == KEY_BS ||
                   i_key_value == KEY_ENT) err_d = 1'b1;
        end
        if (tmr_tc) clear = 1'b1;
      end
      default: state_d = ST_EDIT;
    endcase
    if (clear) begin
      edit_d  = '0;
      cnt_d   = 4'd0;
      state_d = ST_EDIT;
    end
    for (int i = 0; i < DIGITS; i++) blank_d[i] = (4'(i) >= cnt_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_EDIT;
      edit_q         <= '0;
      cnt_q          <= 4'd0;
      commit_q       <= '0;
      o_blank        <= '1;
      o_err          <= 1'b0;
      o_commit_valid <= 1'b0;
      o_hold         <= 1'b0;
    end else begin
      state_q        <= state_d;
      edit_q         <= edit_d;
      cnt_q          <= cnt_d;
      commit_q       <= commit_d;
      o_blank        <= blank_d;
      o_err          <= err_d;
      o_commit_valid <= (state_d == ST_COMMIT);
      o_hold         <= (state_d == ST_HOLD);
    end
  end

  // buffer is frozen through commit/hold, so it already equals the committed value there
  assign o_bcd8d      = edit_q;
  assign o_digit_cnt  = cnt_q;
  assign o_commit_bcd = commit_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed and randomized checks of key_entry_ctrl against a digit-queue reference model.
module tb_key_entry_ctrl;

  localparam int DIGITS = 8;
  localparam int HC     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kv  = 1'b0;
  logic [4:0]  kval = 5'd0;
  logic [31:0] bcd, cbcd;
  logic [7:0]  blank;
  logic [3:0]  dcnt;
  logic        cv, err, hold;

  key_entry_ctrl #(.DIGITS(DIGITS), .HOLD_CYCLES(HC)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_key_valid    (kv),
    .i_key_value    (kval),
    .o_bcd8d        (bcd),
    .o_blank        (blank),
    .o_digit_cnt    (dcnt),
    .o_commit_valid (cv),
    .o_commit_bcd   (cbcd),
    .o_err          (err),
    .o_hold         (hold)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: entered digits as a queue, newest at the back
  int          dq[$];
  int          mode;      // 0 edit, 1 commit, 2 hold
  int          left;      // hold cycles remaining
  logic [31:0] m_commit;
  logic        m_err;

  function automatic logic [31:0] m_bcd();
    logic [31:0] v = '0;
    for (int j = 0; j < dq.size(); j++) v[4*j +: 4] = 4'(dq[dq.size()-1-j]);
    return v;
  endfunction

  function automatic logic [31:0] m_blank();
    return 32'hFF & ~((32'd1 << dq.size()) - 32'd1);
  endfunction

  task automatic model(input logic r, input logic v, input logic [4:0] k);
    bit dig, abort;
    dig   = (k >= 5'd1 && k <= 5'd10);
    m_err = 1'b0;
    abort = 1'b0;
    if (r) begin
      dq.delete(); mode = 0; m_commit = '0;
    end else if (mode == 0) begin
      if (v) begin
        if (dig) begin
          if (dq.size() < DIGITS) dq.push_back(int'(k) - 1);
          else m_err = 1'b1;
        end else if (k == 5'd11) begin
          if (dq.size() > 0) void'(dq.pop_back());
        end else if (k == 5'd12) begin
          dq.delete();
        end else if (k == 5'd13) begin
          if (dq.size() > 0) begin m_commit = m_bcd(); mode = 1; end
          else m_err = 1'b1;
        end
      end
    end else if (mode == 1) begin
      mode = 2; left = HC;
    end else begin
      if (v && (dig || k == 5'd11 || k == 5'd13)) m_err = 1'b1;
      if (v && k == 5'd12) abort = 1'b1;
      left--;
      if (left == 0 || abort) begin dq.delete(); mode = 0; end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [4:0] k);
    @(negedge clk);
    rst = r; kv = v; kval = k;
    @(posedge clk);
    model(r, v, k);
    #1;
    chk("bcd",    bcd,          m_bcd());
    chk("blank",  32'(blank),   m_blank());
    chk("cnt",    32'(dcnt),    32'(dq.size()));
    chk("cvalid", 32'(cv),      32'(mode == 1));
    chk("cbcd",   cbcd,         m_commit);
    chk("err",    32'(err),     32'(m_err));
    chk("hold",   32'(hold),    32'(mode == 2));
  endtask

  task automatic key(input logic [4:0] k);
    step(1'b0, 1'b1, k);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    int n;
    logic [4:0] k;
    dq.delete(); mode = 0; left = 0; m_commit = '0; m_err = 1'b0;

    step(1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd3);
    chk("rst_blank", 32'(blank), 32'hFF);
    chk("rst_bcd", bcd, 32'h0);

    // digits 1,2,3
    key(5'd2); key(5'd3); key(5'd4);
    chk("t1_bcd", bcd, 32'h0000_0123);
    chk("t1_cnt", 32'(dcnt), 32'd3);
    chk("t1_blank", 32'(blank), 32'hF8);

    // full buffer then overflow
    key(5'd12);
    for (int i = 2; i <= 9; i++) key(5'(i));
    key(5'd10);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_bcd", bcd, 32'h1234_5678);
    chk("t2_cnt", 32'(dcnt), 32'd8);

    // backspace incl. saturation at zero
    key(5'd12);
    key(5'd2); key(5'd3); key(5'd4); key(5'd11);
    chk("t3_bcd", bcd, 32'h0000_0012);
    chk("t3_cnt", 32'(dcnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      key(5'd11);
      chk("t3_bs_err", 32'(err), 32'd0);
    end
    chk("t3_cnt0", 32'(dcnt), 32'd0);

    // commit and full hold
    key(5'd5); key(5'd3); key(5'd13);
    chk("t4_cv", 32'(cv), 32'd1);
    chk("t4_cbcd", cbcd, 32'h42);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (!hold) break;
      n++;
    end
    chk("t4_hold_len", 32'(n), 32'(HC));
    chk("t4_bcd", bcd, 32'h0);
    chk("t4_cnt", 32'(dcnt), 32'd0);
    chk("t4_blank", 32'(blank), 32'hFF);

    // empty ENT, key during commit, digit and CLR during hold
    key(5'd13);
    chk("t5_ent_err", 32'(err), 32'd1);
    chk("t5_ent_cv", 32'(cv), 32'd0);
    key(5'd2); key(5'd13); key(5'd4);
    chk("t5_commit_key_err", 32'(err), 32'd0);
    key(5'd3);
    chk("t5_hold_err", 32'(err), 32'd1);
    chk("t5_hold_bcd", bcd, 32'h1);
    key(5'd12);
    chk("t5_clr_hold", 32'(hold), 32'd0);
    chk("t5_clr_blank", 32'(blank), 32'hFF);

    // reset mid-hold with a key
    key(5'd2); key(5'd13); idle(); idle();
    step(1'b1, 1'b1, 5'd3);
    chk("t6_bcd", bcd, 32'h0);
    chk("t6_blank", 32'(blank), 32'hFF);
    chk("t6_cbcd", cbcd, 32'h0);
    chk("t6_hold", 32'(hold), 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: k = 5'($urandom_range(1, 10));
        4:          k = 5'd11;
        5:          k = ($urandom_range(0, 3) == 0) ? 5'd12 : 5'($urandom_range(1, 10));
        6:          k = 5'd13;
        default:    k = 5'($urandom_range(0, 31));
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), k);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
